// File: rtl/acc_seq_ctrl.sv
// Multi-layer sequencer for the conv accelerator: weight load, input-map load, conv per layer,
// with weight prefetch two groups ahead. Optional watchdog: define ACC_SEQ_WDOG_EN.
module acc_seq_ctrl #(
  parameter int CH_W     = 8,
  parameter int LAYER_W  = 4,
  parameter int OCH_PAR  = 16,
  parameter int WDOG_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CH_W-1:0]    cfg_out_ch,
  input  logic [LAYER_W-1:0] cfg_num_layers,
  input  logic               acc_start,
  input  logic               acc_abort,
  output logic               acc_busy,
  output logic               acc_done,
  output logic               acc_err,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               weight_start,
  output logic [CH_W-1:0]    weight_och,
  input  logic               weight_done,
  output logic               imap_start,
  input  logic               imap_done,
  output logic               conv_start,
  input  logic               conv_grp_done,
  input  logic               conv_done
);
  localparam int SH = $clog2(OCH_PAR);

  if (OCH_PAR < 1 || (OCH_PAR & (OCH_PAR - 1)) != 0 || WDOG_CYC < 1) begin : g_param_chk
    $error("acc_seq_ctrl: OCH_PAR must be a power of two and WDOG_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, WLOAD, ILOAD, CONV} state_e;

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d, nl_q, nl_d;
  logic [CH_W:0]      grps_q, grps_d;
  logic [CH_W-1:0]    grp_q, grp_d, wo_q, wo_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               ws_q, ws_d, is_q, is_d, cs_q, cs_d;
  logic [CH_W:0]      g_calc;
  logic [CH_W+1:0]    pf_grp;
  logic               any_done, wdog_hit;

  assign g_calc   = ({1'b0, cfg_out_ch} + (CH_W+1)'(OCH_PAR - 1)) >> SH;
  assign pf_grp   = {2'b00, grp_q} + (CH_W+2)'(2);
  assign any_done = weight_done | imap_done | conv_grp_done | conv_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      layer_q <= '0;
      nl_q    <= '0;
      grps_q  <= '0;
      grp_q   <= '0;
      wo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ws_q    <= 1'b0;
      is_q    <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      nl_q    <= nl_d;
      grps_q  <= grps_d;
      grp_q   <= grp_d;
      wo_q    <= wo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ws_q    <= ws_d;
      is_q    <= is_d;
      cs_q    <= cs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    nl_d    = nl_q;
    grps_d  = grps_q;
    grp_d   = grp_q;
    wo_d    = wo_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ws_d    = 1'b0;
    is_d    = 1'b0;
    cs_d    = 1'b0;
    unique case (state_q)
      IDLE: if (acc_start && !acc_abort) begin
        if (cfg_num_layers == '0 || cfg_out_ch == '0) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          state_d = WLOAD;
          layer_d = '0;
          nl_d    = cfg_num_layers;
          grps_d  = g_calc;
          ws_d    = 1'b1;
          wo_d    = '0;
        end
      end
      WLOAD: if (weight_done) begin
        state_d = ILOAD;
        is_d    = 1'b1;
      end
      ILOAD: if (imap_done) begin
        state_d = CONV;
        cs_d    = 1'b1;
        grp_d   = '0;
        if (grps_q > (CH_W+1)'(1)) begin
          ws_d = 1'b1;
          wo_d = CH_W'(OCH_PAR);
        end
      end
      CONV: begin
        // conv_done takes priority over a coincident group-done: no prefetch then
        if (conv_done) begin
          if (({1'b0, layer_q} + (LAYER_W+1)'(1)) < {1'b0, nl_q}) begin
            state_d = WLOAD;
            layer_d = layer_q + LAYER_W'(1);
            ws_d    = 1'b1;
            wo_d    = '0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (conv_grp_done) begin
          grp_d = grp_q + CH_W'(1);
          if (pf_grp < {1'b0, grps_q}) begin
            ws_d = 1'b1;
            wo_d = CH_W'(pf_grp << SH);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (wdog_hit) begin
      state_d = IDLE;
      ws_d    = 1'b0;
      is_d    = 1'b0;
      cs_d    = 1'b0;
      done_d  = 1'b1;
      err_d   = 1'b1;
    end
    if (state_q != IDLE && acc_abort) begin
      state_d = IDLE;
      ws_d    = 1'b0;
      is_d    = 1'b0;
      cs_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

`ifdef ACC_SEQ_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;

  // counter value v means v+1 cycles spent without progress in the current state
  assign wdog_hit = (state_q != IDLE) && !any_done && (wdog_q == WD_W'(WDOG_CYC - 1));
  assign wdog_d   = (state_q == IDLE || state_d != state_q || any_done) ? '0 : wdog_q + WD_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  logic unused_done;
  assign unused_done = any_done;
  assign wdog_hit    = 1'b0;
`endif

  assign acc_busy     = busy_q;
  assign acc_done     = done_q;
  assign acc_err      = err_q;
  assign layer_idx    = layer_q;
  assign weight_start = ws_q;
  assign weight_och   = wo_q;
  assign imap_start   = is_q;
  assign conv_start   = cs_q;
endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Scoreboard bench for acc_seq_ctrl: stimulus pushes expected pulse events, a monitor pops and compares.
module tb_acc_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cfg_out_ch = '0;
  logic [3:0] cfg_num_layers = '0;
  logic       acc_start = 0, acc_abort = 0, weight_done = 0, imap_done = 0;
  logic       conv_grp_done = 0, conv_done = 0;
  logic       acc_busy, acc_done, acc_err, weight_start, imap_start, conv_start;
  logic [3:0] layer_idx;
  logic [7:0] weight_och;

  acc_seq_ctrl #(.CH_W(8), .LAYER_W(4), .OCH_PAR(16), .WDOG_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_out_ch(cfg_out_ch), .cfg_num_layers(cfg_num_layers),
    .acc_start(acc_start), .acc_abort(acc_abort), .acc_busy(acc_busy), .acc_done(acc_done),
    .acc_err(acc_err), .layer_idx(layer_idx), .weight_start(weight_start),
    .weight_och(weight_och), .weight_done(weight_done), .imap_start(imap_start),
    .imap_done(imap_done), .conv_start(conv_start), .conv_grp_done(conv_grp_done),
    .conv_done(conv_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    bit       ws;
    bit [7:0] wo;
    bit       is, cs, dn, er;
    bit [3:0] li;
  } ev_t;
  ev_t q[$];
  int n_cmp = 0, n_bad = 0;

  task automatic push_at(input int c, input bit ws, input bit [7:0] wo, input bit is, input bit cs,
                         input bit dn, input bit er, input bit [3:0] li);
    ev_t e;
    e.cyc = c; e.ws = ws; e.wo = wo; e.is = is; e.cs = cs; e.dn = dn; e.er = er; e.li = li;
    q.push_back(e);
  endtask

  // expected pulse in the cycle after the inputs just driven are sampled
  task automatic expect_ev(input bit ws, input bit [7:0] wo, input bit is, input bit cs,
                           input bit dn, input bit er, input bit [3:0] li);
    push_at(cyc + 1, ws, wo, is, cs, dn, er, li);
  endtask

  task automatic tick(input bit st, input bit ab, input bit wd, input bit id, input bit gd,
                      input bit cd);
    @(posedge clk);
    #1;
    acc_start = st; acc_abort = ab; weight_done = wd; imap_done = id;
    conv_grp_done = gd; conv_done = cd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (weight_start || imap_start || conv_start || acc_done || acc_err) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse cyc=%0d ws=%b och=%0d is=%b cs=%b done=%b err=%b",
                 cyc, weight_start, weight_och, imap_start, conv_start, acc_done, acc_err);
      end else begin
        ev_t e;
        bit  ok;
        e  = q.pop_front();
        ok = (cyc == e.cyc) && (weight_start == e.ws) && (!e.ws || weight_och == e.wo) &&
             (imap_start == e.is) && (conv_start == e.cs) && (acc_done == e.dn) &&
             (acc_err == e.er) && (!(e.ws || e.is || e.cs) || layer_idx == e.li);
        if (!ok) begin
          n_bad++;
          $display("FAIL event: got cyc=%0d ws=%b och=%0d is=%b cs=%b done=%b err=%b li=%0d; want cyc=%0d ws=%b och=%0d is=%b cs=%b done=%b err=%b li=%0d",
                   cyc, weight_start, weight_och, imap_start, conv_start, acc_done, acc_err,
                   layer_idx, e.cyc, e.ws, e.wo, e.is, e.cs, e.dn, e.er, e.li);
        end
      end
    end
  end

  initial begin
    // reset values
    idle(3);
    chk("rst_busy", acc_busy, 0);
    chk("rst_done", acc_done, 0);
    chk("rst_err", acc_err, 0);
    chk("rst_layer", layer_idx, 0);
    chk("rst_ws", weight_start, 0);
    chk("rst_och", weight_och, 0);
    chk("rst_is_cs", {imap_start, conv_start}, 0);
    rst_n = 1'b1;
    idle(2);

    // single layer, out_ch=64: och 0, 16 with conv_start, 32, 48
    cfg_num_layers = 1; cfg_out_ch = 64;
    tick(1, 0, 0, 0, 0, 0); expect_ev(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("s1_busy", acc_busy, 1);
    cfg_out_ch = 16;  // must not affect the running layer
    tick(0, 0, 1, 0, 0, 0); expect_ev(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    tick(0, 0, 0, 1, 0, 0); expect_ev(1, 16, 0, 1, 0, 0, 0);
    idle(2);
    tick(0, 0, 0, 0, 1, 0); expect_ev(1, 32, 0, 0, 0, 0, 0);
    idle(1);
    tick(0, 0, 0, 0, 1, 0); expect_ev(1, 48, 0, 0, 0, 0, 0);
    idle(1);
    tick(0, 0, 0, 0, 1, 0);
    idle(1);
    tick(0, 0, 0, 0, 0, 1); expect_ev(0, 0, 0, 0, 1, 0, 0);
    idle(1);
    chk("s1_busy_after_done", acc_busy, 0);
    idle(2);

    // three layers of one group each, with stray inputs that must be ignored
    cfg_num_layers = 3; cfg_out_ch = 16;
    for (int l = 0; l < 3; l++) begin
      if (l == 0) begin
        tick(1, 0, 0, 0, 0, 0); expect_ev(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        tick(1, 0, 0, 1, 0, 1);  // start while busy, stray imap/conv done
        idle(1);
      end
      tick(0, 0, 1, 0, 0, 0); expect_ev(0, 0, 1, 0, 0, 0, 4'(l));
      idle(1);
      tick(0, 0, 0, 1, 0, 0); expect_ev(0, 0, 0, 1, 0, 0, 4'(l));
      idle(1);
      tick(0, 0, 0, 0, 1, 0);
      idle(1);
      tick(0, 0, 0, 0, 0, 1);
      if (l < 2) expect_ev(1, 0, 0, 0, 0, 0, 4'(l + 1));
      else       expect_ev(0, 0, 0, 0, 1, 0, 0);
      idle(1);
    end
    chk("s2_layer_final", layer_idx, 2);
    idle(2);

    // out_ch=40 (G=3): prefetch 16, then 32, then nothing
    cfg_num_layers = 1; cfg_out_ch = 40;
    tick(1, 0, 0, 0, 0, 0); expect_ev(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0); expect_ev(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0); expect_ev(1, 16, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0); expect_ev(1, 32, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 1); expect_ev(0, 0, 0, 0, 1, 0, 0);
    idle(3);

    // G=4, conv_grp_done with conv_done: next layer starts at och 0, no prefetch
    cfg_num_layers = 2; cfg_out_ch = 64;
    tick(1, 0, 0, 0, 0, 0); expect_ev(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0); expect_ev(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0); expect_ev(1, 16, 0, 1, 0, 0, 0);
    idle(1);
    tick(0, 0, 0, 0, 1, 1); expect_ev(1, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 1, 0, 0, 0); expect_ev(0, 0, 1, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 0, 0); expect_ev(1, 16, 0, 1, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1); expect_ev(0, 0, 0, 0, 1, 0, 0);
    idle(3);

    // abort in ILOAD, restart two cycles later
    cfg_num_layers = 1; cfg_out_ch = 16;
    tick(1, 0, 0, 0, 0, 0); expect_ev(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0); expect_ev(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    tick(0, 1, 0, 1, 0, 0);  // abort beats the imap_done
    idle(1);
    chk("abort_busy", acc_busy, 0);
    tick(1, 0, 0, 0, 0, 0); expect_ev(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0); expect_ev(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0); expect_ev(0, 0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1); expect_ev(0, 0, 0, 0, 1, 0, 0);
    idle(2);

    // abort in IDLE blocks a coincident start
    tick(1, 1, 0, 0, 0, 0);
    idle(1);
    chk("idle_abort_busy", acc_busy, 0);
    idle(1);

    // zero configurations end at once with an error
    cfg_num_layers = 0; cfg_out_ch = 16;
    tick(1, 0, 0, 0, 0, 0); expect_ev(0, 0, 0, 0, 1, 1, 0);
    idle(1);
    chk("zero_nl_busy", acc_busy, 0);
    cfg_num_layers = 2; cfg_out_ch = 0;
    tick(1, 0, 0, 0, 0, 0); expect_ev(0, 0, 0, 0, 1, 1, 0);
    idle(1);
    chk("zero_och_busy", acc_busy, 0);
    idle(1);

    // reset in the middle of layer 1
    cfg_num_layers = 2; cfg_out_ch = 16;
    tick(1, 0, 0, 0, 0, 0); expect_ev(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0); expect_ev(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0); expect_ev(0, 0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1); expect_ev(1, 0, 0, 0, 0, 0, 1);
    idle(1);
    rst_n = 1'b0;
    tick(0, 0, 1, 0, 0, 0);  // weight_done during reset: no pulse afterwards
    chk("mrst_busy", acc_busy, 0);
    chk("mrst_layer", layer_idx, 0);
    rst_n = 1'b1;
    idle(3);

`ifdef ACC_SEQ_WDOG_EN
    // watchdog: weight_done withheld, error end 101 cycles after the start
    begin
      int c0;
      cfg_num_layers = 1; cfg_out_ch = 16;
      tick(1, 0, 0, 0, 0, 0); expect_ev(1, 0, 0, 0, 0, 0, 0);
      c0 = cyc;
      push_at(c0 + 101, 0, 0, 0, 0, 1, 1, 0);
      idle(105);
      chk("wdog_busy", acc_busy, 0);
    end
`endif

    idle(2);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
